// File: rtl/nes_pad_pkg.sv
// Shared definitions for the NES controller poller: FSM states, button bit
// positions and protocol timing constants.
package nes_pad_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LATCH  = 3'd1,
        CLK_HI = 3'd2,
        CLK_LO = 3'd3,
        DONE   = 3'd4
    } state_e;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam int LATCH_TICKS = 2;
    localparam int NUM_PULSES  = 7;

endpackage

// File: rtl/tick_gen.sv
// Protocol tick prescaler: counts 0..TICK_CYCLES-1 and flags the last count.
module tick_gen #(
    parameter int TICK_CYCLES = 300
) (
    input  logic clk,
    input  logic Reset,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == CW'(TICK_CYCLES - 1));

    // Next count: clear wins, otherwise wrap on tick.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nes_pad_poller.sv
// NES controller poller: latches the pad's 4021, clocks out 8 bits and
// publishes them active-high, on request or periodically.
module nes_pad_poller
    import nes_pad_pkg::*;
#(
    parameter int TICK_CYCLES = 300,
    parameter int POLL_TICKS  = 2778
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       auto_en,
    input  logic       poll_req,
    input  logic       pad_data,
    output logic       pad_latch,
    output logic       pad_clk,
    output logic [7:0] buttons,
    output logic       buttons_valid,
    output logic       busy
);

    localparam int TW = $clog2(POLL_TICKS);

    state_e        state_q, state_d;
    logic [0:0]    lat_cnt_q, lat_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    data_q, data_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    buttons_q;
    logic          pad_latch_q, pad_clk_q, valid_q, busy_q;
    logic          tick_s, auto_hit_s, start_s;

    tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
        .clk   (clk),
        .Reset (Reset),
        .clr   (start_s),
        .tick  (tick_s)
    );

    assign auto_hit_s = auto_en && tick_s && (timer_q == TW'(POLL_TICKS - 1));
    assign start_s    = (state_q == IDLE) && (poll_req || auto_hit_s);

    // Poll timer: counts ticks while auto polling is enabled.
    always_comb begin
        timer_d = timer_q;
        if (!auto_en || start_s) begin
            timer_d = '0;
        end else if (tick_s && (timer_q != TW'(POLL_TICKS - 1))) begin
            timer_d = timer_q + TW'(1);
        end else begin
            timer_d = timer_q;
        end
    end

    // FSM next state; bits are captured on the tick that ends LATCH / CLK_HI.
    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        case (state_q)
            IDLE: begin
                if (start_s) begin
                    state_d   = LATCH;
                    lat_cnt_d = 1'b0;
                    bit_cnt_d = 3'd0;
                    data_d    = 8'h00;
                end else begin
                    state_d = IDLE;
                end
            end
            LATCH: begin
                if (tick_s) begin
                    if (lat_cnt_q == 1'(LATCH_TICKS - 1)) begin
                        state_d        = CLK_HI;
                        data_d[BTN_A]  = pad_data;
                    end else begin
                        lat_cnt_d = lat_cnt_q + 1'b1;
                    end
                end else begin
                    state_d = LATCH;
                end
            end
            CLK_HI: begin
                if (tick_s) begin
                    state_d                     = CLK_LO;
                    data_d[bit_cnt_q + 3'd1]    = pad_data;
                end else begin
                    state_d = CLK_HI;
                end
            end
            CLK_LO: begin
                if (tick_s) begin
                    if (bit_cnt_q == 3'(NUM_PULSES - 1)) begin
                        state_d = DONE;
                    end else begin
                        state_d   = CLK_HI;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    state_d = CLK_LO;
                end
            end
            DONE: begin
                state_d   = IDLE;
                bit_cnt_d = 3'd0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and outputs; outputs follow the state being entered.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            lat_cnt_q   <= 1'b0;
            bit_cnt_q   <= 3'd0;
            data_q      <= 8'h00;
            timer_q     <= '0;
            buttons_q   <= 8'h00;
            pad_latch_q <= 1'b0;
            pad_clk_q   <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            data_q      <= data_d;
            timer_q     <= timer_d;
            pad_latch_q <= (state_d == LATCH);
            pad_clk_q   <= (state_d == CLK_HI);
            valid_q     <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
            if (state_d == DONE) begin
                buttons_q <= ~data_d;
            end else begin
                buttons_q <= buttons_q;
            end
        end
    end

    assign pad_latch     = pad_latch_q;
    assign pad_clk       = pad_clk_q;
    assign buttons       = buttons_q;
    assign buttons_valid = valid_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_nes_pad_poller.sv
// Bench for nes_pad_poller with a behavioural 4021 controller and a
// cycle-index reference for the poll waveform.
module tb_nes_pad_poller;

    localparam int T  = 4;
    localparam int P  = 20;
    localparam int PL = 16 * T + 1;

    logic       clk = 1'b0;
    logic       Reset = 1'b0;
    logic       auto_en = 1'b0;
    logic       poll_req = 1'b0;
    logic       pad_data;
    logic       pad_latch, pad_clk, buttons_valid, busy;
    logic [7:0] buttons;

    logic [7:0] pressed = 8'h00;
    logic [7:0] sr = 8'hFF;
    logic [1:0] mode = 2'd0;
    logic [7:0] cur_btn = 8'h00;
    int         chk = 0;
    int         errs = 0;
    int         nval;

    always #5 clk = ~clk;

    // Controller shift register: parallel load on latch, shift in 1s on clock.
    always @(posedge pad_latch or posedge pad_clk) begin
        if (pad_latch) sr <= ~pressed;
        else           sr <= {1'b1, sr[7:1]};
    end

    assign pad_data = (mode == 2'd0) ? sr[0] : (mode == 2'd1);

    nes_pad_poller #(.TICK_CYCLES(T), .POLL_TICKS(P)) dut (
        .clk           (clk),
        .Reset         (Reset),
        .auto_en       (auto_en),
        .poll_req      (poll_req),
        .pad_data      (pad_data),
        .pad_latch     (pad_latch),
        .pad_clk       (pad_clk),
        .buttons       (buttons),
        .buttons_valid (buttons_valid),
        .busy          (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench inside the first cycle of the requested poll.
    task automatic do_req();
        @(posedge clk);
        #1 poll_req = 1'b1;
        @(posedge clk);
        #1 poll_req = 1'b0;
    endtask

    // Called in cycle 0 of a poll; compares every cycle against the protocol timeline.
    task automatic watch(input logic [7:0] exp_b, input int req_at, input string tag);
        int e_lat = 0, e_clk = 0, e_busy = 0, e_val = 0, e_btn = 0, n_val = 0;
        logic el, ec, eb, ev;
        logic [7:0] ebtn;
        for (int i = 0; i < PL + 3; i++) begin
            @(negedge clk);
            el   = (i < 2 * T);
            ec   = (i >= 2 * T) && (i < 16 * T) && ((((i - 2 * T) / T) % 2) == 0);
            eb   = (i < PL);
            ev   = (i == PL - 1);
            ebtn = (i >= PL - 1) ? exp_b : cur_btn;
            if (pad_latch !== el)     e_lat++;
            if (pad_clk !== ec)       e_clk++;
            if (busy !== eb)          e_busy++;
            if (buttons_valid !== ev) e_val++;
            if (buttons !== ebtn)     e_btn++;
            if (buttons_valid === 1'b1) n_val++;
            poll_req = (i == req_at);
        end
        poll_req = 1'b0;
        check({tag, "_latch"}, e_lat, 0);
        check({tag, "_padclk"}, e_clk, 0);
        check({tag, "_busy"}, e_busy, 0);
        check({tag, "_valid_timing"}, e_val, 0);
        check({tag, "_valid_count"}, n_val, 1);
        check({tag, "_buttons"}, e_btn, 0);
        check({tag, "_final"}, buttons, exp_b);
        cur_btn = exp_b;
    endtask

    // Idle gap of n cycles; optionally requests a poll in the last cycle.
    task automatic wait_idle(input int n, input bit req_last, input string tag);
        int e = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || pad_latch !== 1'b0 || buttons_valid !== 1'b0) e++;
            poll_req = req_last && (i == n - 1);
        end
        @(posedge clk);
        #1 poll_req = 1'b0;
        check({tag, "_gap"}, e, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_latch", pad_latch, 1'b0);
        check("rst_padclk", pad_clk, 1'b0);
        check("rst_buttons", buttons, 8'h00);
        check("rst_valid", buttons_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(negedge clk) Reset = 1'b1;
        repeat (2) @(negedge clk);

        pressed = 8'h09;
        do_req();
        watch(8'h09, -1, "a_start");
        for (int k = 0; k < 4; k++) begin
            pressed = 8'($urandom);
            do_req();
            watch(pressed, -1, "rand");
        end

        mode = 2'd1;
        do_req();
        watch(8'h00, -1, "no_pad");
        mode = 2'd2;
        do_req();
        watch(8'hFF, -1, "all_low");
        mode = 2'd0;

        pressed = 8'h5A;
        do_req();
        watch(8'h5A, 10, "double_req");

        // Reset in the 4th CLK_HI.
        pressed = 8'hC3;
        do_req();
        repeat (34) @(negedge clk);
        check("mid_pre_padclk", pad_clk, 1'b1);
        Reset = 1'b0;
        #1;
        check("mid_padclk", pad_clk, 1'b0);
        check("mid_buttons", buttons, 8'h00);
        check("mid_busy", busy, 1'b0);
        check("mid_latch", pad_latch, 1'b0);
        cur_btn = 8'h00;
        nval = 0;
        repeat (4) begin
            @(negedge clk);
            if (buttons_valid === 1'b1) nval++;
        end
        Reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (buttons_valid === 1'b1 || busy === 1'b1) nval++;
        end
        check("mid_no_valid", nval, 0);
        pressed = 8'($urandom);
        do_req();
        watch(pressed, -1, "after_reset");

        // Periodic polling from reset release.
        @(negedge clk);
        Reset   = 1'b0;
        auto_en = 1'b1;
        cur_btn = 8'h00;
        pressed = 8'($urandom);
        @(posedge clk);
        #1 Reset = 1'b1;
        repeat (79) @(posedge clk);
        @(negedge clk);
        check("auto_pre_busy", busy, 1'b0);
        check("auto_pre_latch", pad_latch, 1'b0);
        @(posedge clk);
        #1;
        watch(pressed, -1, "auto1");
        pressed = 8'($urandom);
        wait_idle(80 - (PL + 3), 1'b0, "auto2");
        watch(pressed, -1, "auto2");
        pressed = 8'($urandom);
        wait_idle(5, 1'b1, "early_req");
        watch(pressed, -1, "early_req");
        pressed = 8'($urandom);
        wait_idle(80 - (PL + 3), 1'b0, "auto_after_req");
        watch(pressed, -1, "auto_after_req");
        pressed = 8'($urandom);
        wait_idle(80 - (PL + 3), 1'b1, "coincide");
        watch(pressed, -1, "coincide");
        pressed = 8'($urandom);
        wait_idle(80 - (PL + 3), 1'b0, "auto_after_coincide");
        watch(pressed, -1, "auto_after_coincide");

        $display("Simulation finished: %0d checks, %0d errors", chk, errs);
        $finish;
    end

endmodule
